mult_div_unit: RTL
==================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU. It takes the `MDstart`/`MDop` controls decoded for the E-stage instruction, sequences signed/unsigned multiply and divide over a fixed number of cycles, and handles `mthi`/`mtlo`/`mfhi`/`mflo`. It asserts a stall request toward the hazard unit while a D-stage instruction that touches HI/LO would observe an in-flight operation.

## Interface
- `MULT_CYCLES`, 5, busy cycles for `mult`/`multu` (≥1, ≤15)
- `DIV_CYCLES`, 10, busy cycles for `div`/`divu` (≥1, ≤15)

- `clk`  in  1  rising-edge clock; sole clock
- `reset`  in  1  synchronous, active-high
- `MDstart`  in  1  E-stage instruction is mult/multu/div/divu
- `MDop`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo/none
- `A`  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
- `B`  in  32  forwarded rt value (divisor / multiplier)
- `MDuse_D`  in  1  D-stage instruction is any of the eight MD instructions
- `MDout`  out  32  HI if `MDop`=110, else LO; combinational
- `HI`, `LO`  out  32 each  architectural registers
- `busy`  out  1  operation in flight
- `stall_MD`  out  1  `MDuse_D & (busy | MDstart)`

## Operation
- FSM: IDLE, RUN. 4-bit down-counter `cnt`.
- IDLE, `MDstart`=1: compute full result from `A`,`B` into pending regs `hi_p`,`lo_p`; `cnt` ← MULT_CYCLES or DIV_CYCLES; → RUN. HI/LO unchanged this edge.
- Mult: 64-bit product; `multu` zero-extends, `mult` sign-extends. `hi_p`=[63:32], `lo_p`=[31:0].
- Div: `lo_p`=quotient, `hi_p`=remainder; `div` signed, truncate toward zero, remainder takes sign of dividend; `divu` unsigned.
- Divide by zero (`B`=0): still runs DIV_CYCLES; HI/LO left unchanged at commit.
- RUN: `cnt` decrements each edge; at edge where `cnt`=1: HI←`hi_p`, LO←`lo_p` (unless div-by-zero), → IDLE.
- `busy` = (state == RUN).
- IDLE, `MDop`=100 and `MDstart`=0: HI←`A`; `MDop`=101: LO←`A`. In RUN, mthi/mtlo are ignored (hazard unit prevents them via `stall_MD`).
- `MDstart` while RUN: ignored (cannot occur with correct stalling; bench checks it has no effect).
- `MDout` reads current HI/LO; mfhi/mflo are never in E while busy because of `stall_MD`.

## Timing
- Reset (sync): HI=0, LO=0, state=IDLE, `cnt`=0, `busy`=0, pending regs 0. Reset in RUN aborts the operation; no commit.
- Start sampled at edge E0; `busy`=1 for cycles after E0 through the cycle ending at edge E0+N (N = MULT_CYCLES/DIV_CYCLES); HI/LO new at E0+N; `busy`=0 from E0+N.
- `stall_MD` is combinational so the D-stage consumer stalls the cycle its producer is in E (`MDstart`) and all busy cycles; the first unstalled cycle sees `busy`=0 and committed HI/LO.
- Back-to-back: new start accepted at edge E0+N+1 earliest (first IDLE cycle).
- mthi/mtlo take effect at the edge they are in E; following mfhi in E next cycle reads the new value.

## Test plan
- mult A=0xFFFFFFFD (−3), B=5 → `busy` 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO unchanged during busy.
- multu A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 → LO=3, HI=1.
- mthi A=0x1234 then divu B=0 → HI=0x1234 throughout and after 10 busy cycles; LO unchanged.
- `MDuse_D`=1 alongside mult start → `stall_MD` high 6 cycles (start cycle + 5 busy), low when `busy` falls; mthi asserted in RUN → HI unaffected.
- reset asserted 3 cycles into a div → next cycle HI=LO=0, `busy`=0; no late commit afterwards.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// E-stage multiply/divide interface: pipeline controls and operands in,
// HI/LO state, read mux, busy and hazard stall out.
interface mult_div_unit_if;
  logic        MDstart;
  logic [2:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        MDuse_D;
  logic [31:0] MDout;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        stall_MD;

  modport master (output MDstart, MDop, A, B, MDuse_D,
                  input  MDout, HI, LO, busy, stall_MD);
  modport slave  (input  MDstart, MDop, A, B, MDuse_D,
                  output MDout, HI, LO, busy, stall_MD);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/div unit with HI/LO. The result is computed at start and
// held in pending registers; the busy window only models the unit latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_r, lo_r, hi_p, lo_p;
  logic        dz;

  logic        is_div, sgn;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign is_div = md.MDop[1];
  assign sgn    = ~md.MDop[0];

  // Sign/zero extension to 64 bits makes one unsigned multiply serve both.
  always_comb begin
    a_ext = {{32{sgn & md.A[31]}}, md.A};
    b_ext = {{32{sgn & md.B[31]}}, md.B};
    prod  = a_ext * b_ext;
  end

  // Divide on magnitudes, then fix signs: quotient truncates toward zero,
  // remainder follows the dividend. Zero divisor is masked to avoid X.
  always_comb begin
    a_mag  = (sgn & md.A[31]) ? -md.A : md.A;
    b_mag  = (sgn & md.B[31]) ? -md.B : md.B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (sgn & (md.A[31] ^ md.B[31])) ? -q_mag : q_mag;
    rem    = (sgn & md.A[31]) ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
      hi_p  <= 32'd0;
      lo_p  <= 32'd0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.MDstart) begin
            hi_p  <= is_div ? rem : prod[63:32];
            lo_p  <= is_div ? quo : prod[31:0];
            dz    <= is_div & (md.B == 32'd0);
            cnt   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            state <= RUN;
          end else if (md.MDop == 3'b100) begin
            hi_r <= md.A;
          end else if (md.MDop == 3'b101) begin
            lo_r <= md.A;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!dz) begin
              hi_r <= hi_p;
              lo_r <= lo_p;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.HI       = hi_r;
  assign md.LO       = lo_r;
  assign md.busy     = (state == RUN);
  assign md.MDout    = (md.MDop == 3'b110) ? hi_r : lo_r;
  assign md.stall_MD = md.MDuse_D & (md.busy | md.MDstart);

endmodule
